// File: rtl/bc_pkg.sv
// Shared types and control-word constants for the bc_polinomio block.
// State encoding, BO mux selects and ULA op codes.
package bc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MUL_A,
    ADD_B,
    MUL_X,
    ADD_C,
    DONE
  } state_t;

  localparam logic [1:0] SEL_ZERO = 2'd0;
  localparam logic [1:0] SEL_A    = 2'd1;
  localparam logic [1:0] SEL_B    = 2'd2;
  localparam logic [1:0] SEL_C    = 2'd3;

  localparam logic [1:0] OP1_M0 = 2'd0;
  localparam logic [1:0] OP1_R0 = 2'd1;
  localparam logic [1:0] OP1_R1 = 2'd2;
  localparam logic [1:0] OP1_R2 = 2'd3;

  localparam logic [1:0] OP2_R0 = 2'd0;
  localparam logic [1:0] OP2_M0 = 2'd1;
  localparam logic [1:0] OP2_R1 = 2'd2;
  localparam logic [1:0] OP2_R2 = 2'd3;

  localparam logic H_MUL = 1'b1;
  localparam logic H_ADD = 1'b0;

endpackage

// File: rtl/bc_polinomio_wait_cnt.sv
// bc_wait_cnt: 2-bit wait counter, clear has priority over enable.
// Ports: clk, rst (async active-low), clr, en, term (cnt == LAT).
module bc_wait_cnt #(
  parameter int LAT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic term
);

  localparam logic [1:0] LIM = 2'(LAT);

  logic [1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 2'd1;
    end
  end

  assign term = (cnt == LIM);

endmodule

// File: rtl/bc_polinomio.sv
// Control block sequencing BO through y = ((A*x)+B)*x + C.
// Ports: clk, rst (async low), start, busy, done, M0/M1/M2, LX/LH/LS, H; step if BC_STEP_EN.
module bc_polinomio
  import bc_pkg::*;
#(
  parameter int ULA_LAT = 0
) (
  input  logic       clk,
  input  logic       rst,
`ifdef BC_STEP_EN
  input  logic       step,
`endif
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [1:0] M0,
  output logic [1:0] M1,
  output logic [1:0] M2,
  output logic       LX,
  output logic       LH,
  output logic       LS,
  output logic       H
);

  state_t state;
  logic   adv;
  logic   arith;
  logic   term;

`ifdef BC_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  assign arith = (state == MUL_A) || (state == ADD_B) ||
                 (state == MUL_X) || (state == ADD_C);

  bc_wait_cnt #(
    .LAT (ULA_LAT)
  ) u_wait (
    .clk  (clk),
    .rst  (rst),
    .clr  (arith && adv && term),
    .en   (arith && adv),
    .term (term)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start) state <= LOAD;
        LOAD:    if (adv) state <= MUL_A;
        MUL_A:   if (adv && term) state <= ADD_B;
        ADD_B:   if (adv && term) state <= MUL_X;
        MUL_X:   if (adv && term) state <= ADD_C;
        ADD_C:   if (adv && term) state <= DONE;
        DONE:    state <= start ? LOAD : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Loads only fire on a cycle that actually advances the sequence.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    M0   = SEL_ZERO;
    M1   = OP1_M0;
    M2   = OP2_R0;
    LX   = 1'b0;
    LS   = 1'b0;
    H    = H_ADD;
    unique case (state)
      LOAD: begin
        busy = 1'b1;
        LX   = adv;
      end
      MUL_A: begin
        busy = 1'b1;
        M0   = SEL_A;
        M1   = OP1_M0;
        M2   = OP2_R0;
        H    = H_MUL;
        LS   = term && adv;
      end
      ADD_B: begin
        busy = 1'b1;
        M0   = SEL_B;
        M1   = OP1_R2;
        M2   = OP2_M0;
        H    = H_ADD;
        LS   = term && adv;
      end
      MUL_X: begin
        busy = 1'b1;
        M0   = SEL_ZERO;
        M1   = OP1_R2;
        M2   = OP2_R0;
        H    = H_MUL;
        LS   = term && adv;
      end
      ADD_C: begin
        busy = 1'b1;
        M0   = SEL_C;
        M1   = OP1_R2;
        M2   = OP2_M0;
        H    = H_ADD;
        LS   = term && adv;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign LH = 1'b0;

endmodule

// File: tb/tb_bc_polinomio.sv
// Bench for bc_polinomio: two instances (ULA_LAT 0 and 2) driving BO models.
// Control words checked each cycle against a spec-level sequence model.
module tb_bc_polinomio;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [1:0] m0;
    logic [1:0] m1;
    logic [1:0] m2;
    logic       lx;
    logic       lh;
    logic       ls;
    logic       h;
  } ctl_t;

  typedef struct {
    logic [31:0] x;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] y;
  } vec_t;

  logic clk = 0;
  logic rst = 0;
  logic start = 0;
  logic step = 1;
  int   step_mode = 0;
  int   ncmp = 0;
  int   nerr = 0;
  int   nd0, nd2, md0, md2;
  int   p0, p2;
  logic [31:0] ox, oa, ob, oc, yexp;

  logic       busy0, done0, lx0, lh0, ls0, h0;
  logic [1:0] m00, m10, m20;
  logic       busy2, done2, lx2, lh2, ls2, h2;
  logic [1:0] m02, m12, m22;
  ctl_t ctl0, ctl2;

  assign ctl0 = {busy0, done0, m00, m10, m20, lx0, lh0, ls0, h0};
  assign ctl2 = {busy2, done2, m02, m12, m22, lx2, lh2, ls2, h2};

  always #5 clk = ~clk;

  bc_polinomio #(.ULA_LAT(0)) d0 (
    .clk(clk), .rst(rst),
`ifdef BC_STEP_EN
    .step(step),
`endif
    .start(start), .busy(busy0), .done(done0),
    .M0(m00), .M1(m10), .M2(m20),
    .LX(lx0), .LH(lh0), .LS(ls0), .H(h0)
  );

  bc_polinomio #(.ULA_LAT(2)) d2 (
    .clk(clk), .rst(rst),
`ifdef BC_STEP_EN
    .step(step),
`endif
    .start(start), .busy(busy2), .done(done2),
    .M0(m02), .M1(m12), .M2(m22),
    .LX(lx2), .LH(lh2), .LS(ls2), .H(h2)
  );

  // BO datapath model.
  function automatic logic [31:0] ula(ctl_t w, logic [31:0] r0,
                                      logic [31:0] r1, logic [31:0] r2);
    logic [31:0] mo, o1, o2;
    case (w.m0)
      2'd0: mo = 0;
      2'd1: mo = oa;
      2'd2: mo = ob;
      default: mo = oc;
    endcase
    case (w.m1)
      2'd0: o1 = mo;
      2'd1: o1 = r0;
      2'd2: o1 = r1;
      default: o1 = r2;
    endcase
    case (w.m2)
      2'd0: o2 = r0;
      2'd1: o2 = mo;
      2'd2: o2 = r1;
      default: o2 = r2;
    endcase
    return w.h ? o1 * o2 : o1 + o2;
  endfunction

  logic [31:0] a0r0 = 0, a0r1 = 0, a0r2 = 0;
  logic [31:0] a2r0 = 0, a2r1 = 0, a2r2 = 0;

  always @(posedge clk) begin
    if (lx0) a0r0 <= ox;
    if (lh0) a0r1 <= ula(ctl0, a0r0, a0r1, a0r2);
    if (ls0) a0r2 <= ula(ctl0, a0r0, a0r1, a0r2);
    if (lx2) a2r0 <= ox;
    if (lh2) a2r1 <= ula(ctl2, a2r0, a2r1, a2r2);
    if (ls2) a2r2 <= ula(ctl2, a2r0, a2r1, a2r2);
  end

  // Expected control word: position 0 is the load cycle, then four
  // steps of lat+1 cycles each, then the done cycle; -1 means idle.
  function automatic ctl_t exp_word(int lat, int pos, logic stp);
    ctl_t w;
    int   op, sub;
    w = '0;
    if (pos < 0) return w;
    if (pos == 4 * (lat + 1) + 1) begin
      w.done = 1;
      return w;
    end
    w.busy = 1;
    if (pos == 0) begin
      w.lx = stp;
      return w;
    end
    op  = (pos - 1) / (lat + 1);
    sub = (pos - 1) % (lat + 1);
    case (op)
      0: begin w.m0 = 1; w.m1 = 0; w.m2 = 0; w.h = 1; end
      1: begin w.m0 = 2; w.m1 = 3; w.m2 = 1; w.h = 0; end
      2: begin w.m0 = 0; w.m1 = 3; w.m2 = 0; w.h = 1; end
      default: begin w.m0 = 3; w.m1 = 3; w.m2 = 1; w.h = 0; end
    endcase
    w.ls = (sub == lat) && stp;
    return w;
  endfunction

  function automatic int nxt(int lat, int pos, logic st, logic stp);
    if (pos < 0 || pos == 4 * (lat + 1) + 1) return st ? 0 : -1;
    return stp ? pos + 1 : pos;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      p0 <= -1;
      p2 <= -1;
    end else begin
      p0 <= nxt(0, p0, start, step);
      p2 <= nxt(2, p2, start, step);
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    ctl_t e0, e2;
    #2;
    e0 = exp_word(0, p0, step);
    e2 = exp_word(2, p2, step);
    chk("ctl0", 32'(ctl0), 32'(e0));
    chk("ctl2", 32'(ctl2), 32'(e2));
    if (e0.done) md0++;
    if (e2.done) md2++;
    if (done0) begin
      nd0++;
      chk("y0", a0r2, yexp);
    end
    if (done2) begin
      nd2++;
      chk("y2", a2r2, yexp);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      case (step_mode)
        1: step = ($urandom_range(0, 2) == 0);
        2: step = $urandom_range(0, 1) == 1;
        default: step = 1;
      endcase
    end
  end

  task automatic setop(input vec_t v);
    ox = v.x; oa = v.a; ob = v.b; oc = v.c; yexp = v.y;
    nd0 = 0; nd2 = 0; md0 = 0; md2 = 0;
  endtask

  task automatic run(input vec_t v, input int win);
    @(negedge clk);
    setop(v);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (win) @(negedge clk);
    chk("done0 cnt", nd0, 1);
    chk("done2 cnt", nd2, 1);
  endtask

  vec_t tbl[5];
  vec_t v;
  int   win;

  initial begin
    tbl[0] = '{x: 2, a: 3, b: 2, c: 5, y: 21};
    tbl[1] = '{x: 0, a: 7, b: 1, c: 4, y: 4};
    tbl[2] = '{x: 1, a: 1, b: 1, c: 1, y: 3};
    tbl[3] = '{x: 3, a: 1, b: 0, c: 0, y: 9};
    tbl[4] = '{x: 5, a: 2, b: 3, c: 1, y: 66};
    win = 20;
`ifdef BC_STEP_EN
    step_mode = 1;
    win = 70;
`endif
    ox = 0; oa = 0; ob = 0; oc = 0; yexp = 0;
    nd0 = 0; nd2 = 0; md0 = 0; md2 = 0;
    repeat (3) @(negedge clk);
    chk("rst busy0", 32'(busy0), 0);
    chk("rst ctl2", 32'(ctl2), 0);
    rst = 1;
    repeat (2) @(negedge clk);

    foreach (tbl[i]) run(tbl[i], win);

`ifdef BC_STEP_EN
    step_mode = 2;
    win = 110;
`endif
    for (int i = 0; i < 12; i++) begin
      v.x = $urandom_range(0, 255);
      v.a = $urandom_range(0, 255);
      v.b = $urandom_range(0, 255);
      v.c = $urandom_range(0, 255);
      v.y = v.a * v.x * v.x + v.b * v.x + v.c;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run(v, win);
    end

    // start held high: back-to-back runs straight from DONE.
    @(negedge clk);
    setop(tbl[2]);
    start = 1;
    repeat (3 * win) @(negedge clk);
    start = 0;
    repeat (win) @(negedge clk);
    chk("b2b runs0", nd0, md0);
    chk("b2b runs2", nd2, md2);
    chk("b2b multi0", 32'(nd0 >= 2), 1);

    // Reset while the ULA_LAT=0 instance sits in ADD_B.
`ifdef BC_STEP_EN
    step_mode = 0;
`endif
    @(negedge clk);
    setop(tbl[0]);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (2) @(negedge clk);
    #3;
    chk("pre-rst m0", 32'(m00), 2);
    rst = 0;
    #1;
    chk("abort ctl0", 32'(ctl0), 0);
    chk("abort ctl2", 32'(ctl2), 0);
    @(negedge clk);
    rst = 1;
    repeat (20) @(negedge clk);
    chk("abort done0", nd0, 0);
    chk("abort done2", nd2, 0);
    chk("idle busy0", 32'(busy0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
